// File: rtl/fc_stage_pkg.sv
// Shared types and helpers for the fully-connected classifier stages.
package fc_stage_pkg;

  localparam int unsigned FC_WIDTH = 16;

  typedef logic signed [FC_WIDTH-1:0] fc_data_t;

  typedef enum logic {
    ST_FIRST = 1'b0,
    ST_ACC   = 1'b1
  } fc_acc_state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 2) ? int'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/fc_argmax_stage_if.sv
// Input stream and result beat of the argmax stage, bundled with valid/ready.
interface fc_argmax_stage_if
  import fc_stage_pkg::*;
#(
  parameter int unsigned WIDTH = FC_WIDTH,
  parameter int unsigned N     = 4
);
  localparam int unsigned IDXW = idx_width(N);

  logic                    input_valid;
  logic                    input_ready;
  logic signed [WIDTH-1:0] input_data;
  logic                    output_valid;
  logic                    output_ready;
  logic [IDXW-1:0]         output_index;
  logic signed [WIDTH-1:0] output_value;

  // Environment side: produces activations, consumes results
  modport master (
    output input_valid, input_data, output_ready,
    input  input_ready, output_valid, output_index, output_value
  );

  // Stage side
  modport slave (
    input  input_valid, input_data, output_ready,
    output input_ready, output_valid, output_index, output_value
  );

endinterface

// File: rtl/fc_argmax_out_reg.sv
// One-entry result holding register with valid/ready drain; contents stay
// stable until the beat is taken.
module fc_argmax_out_reg #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned IDXW  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [IDXW-1:0]         load_index,
  input  logic signed [WIDTH-1:0] load_value,
  output logic                    valid,
  input  logic                    ready,
  output logic [IDXW-1:0]         index,
  output logic signed [WIDTH-1:0] value
);

  logic                    valid_q, valid_d;
  logic [IDXW-1:0]         index_q, index_d;
  logic signed [WIDTH-1:0] value_q, value_d;

  always_comb begin
    valid_d = valid_q;
    index_d = index_q;
    value_d = value_q;
    if (load) begin
      valid_d = 1'b1;
      index_d = load_index;
      value_d = load_value;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      index_q <= '0;
      value_q <= '0;
    end else begin
      valid_q <= valid_d;
      index_q <= index_d;
      value_q <= value_d;
    end
  end

  assign valid = valid_q;
  assign index = index_q;
  assign value = value_q;

endmodule

// File: rtl/fc_argmax_stage.sv
// Running signed argmax over frames of N activations; the result is parked in a
// one-entry buffer so the next frame can accumulate while it waits.
module fc_argmax_stage
  import fc_stage_pkg::*;
#(
  parameter int unsigned WIDTH = FC_WIDTH,
  parameter int unsigned N     = 4
) (
  input  logic             clk,
  input  logic             reset,
  fc_argmax_stage_if.slave io
);

  localparam int unsigned     IDXW  = idx_width(N);
  localparam logic [IDXW-1:0] LAST  = IDXW'(N - 1);
  localparam bit              MULTI = (N > 1);

  // Asynchronous assert, clock-synchronised release
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n;

  assign rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_q <= '0;
    else        rst_sync_q <= rst_sync_d;
  end

  assign rst_n = rst_sync_q[1];

  fc_acc_state_e           state_q, state_d;
  logic [IDXW-1:0]         count_q, count_d;
  logic [IDXW-1:0]         run_idx_q, run_idx_d;
  logic signed [WIDTH-1:0] run_max_q, run_max_d;

  logic                    last, accept, complete, take_new, out_valid;
  logic [IDXW-1:0]         idx_c;
  logic signed [WIDTH-1:0] max_c;

  // The completing sample waits while the previous result is still buffered
  assign last           = (count_q == LAST);
  assign io.input_ready = rst_n && !(last && out_valid);
  assign accept         = io.input_valid && io.input_ready;
  assign complete       = accept && last;

  assign take_new = (state_q == ST_FIRST) || (io.input_data > run_max_q);
  assign max_c    = take_new ? io.input_data : run_max_q;
  assign idx_c    = take_new ? count_q : run_idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FIRST;
      count_q   <= '0;
      run_idx_q <= '0;
      run_max_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      run_idx_q <= run_idx_d;
      run_max_q <= run_max_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FIRST: if (accept && MULTI) state_d = ST_ACC;
      ST_ACC:   if (complete)        state_d = ST_FIRST;
      default:                       state_d = ST_FIRST;
    endcase
  end

  always_comb begin
    count_d   = count_q;
    run_idx_d = run_idx_q;
    run_max_d = run_max_q;
    if (accept) begin
      run_max_d = max_c;
      run_idx_d = idx_c;
      count_d   = last ? '0 : count_q + IDXW'(1);
    end
  end

  fc_argmax_out_reg #(
    .WIDTH (WIDTH),
    .IDXW  (IDXW)
  ) u_out_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (complete),
    .load_index (idx_c),
    .load_value (max_c),
    .valid      (out_valid),
    .ready      (io.output_ready),
    .index      (io.output_index),
    .value      (io.output_value)
  );

  assign io.output_valid = out_valid;

endmodule

// File: tb/tb_fc_argmax_stage.sv
// Bench for fc_argmax_stage: directed scenarios plus randomized frames against
// a plain argmax reference, for an N=4 and an N=1 build.
module tb_fc_argmax_stage;
  import fc_stage_pkg::*;

  logic clk;
  logic reset;

  fc_argmax_stage_if #(.WIDTH(16), .N(4)) bus  ();
  fc_argmax_stage_if #(.WIDTH(16), .N(1)) bus1 ();

  fc_argmax_stage #(.WIDTH(16), .N(4)) dut  (.clk(clk), .reset(reset), .io(bus.slave));
  fc_argmax_stage #(.WIDTH(16), .N(1)) dut1 (.clk(clk), .reset(reset), .io(bus1.slave));

  int total = 0;
  int bad   = 0;

  int cur[$];
  int exp_idx[$];
  int exp_val[$];
  int exp1[$];
  int n1_outs  = 0;
  bit rnd_rdy  = 0;
  bit n1_phase = 0;

  bit hold;
  int hold_idx, hold_val;

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: first position of the largest signed value
  function automatic void ref_argmax(input int f[$], output int idx, output int val);
    idx = 0;
    val = f[0];
    foreach (f[i]) if (f[i] > val) begin val = f[i]; idx = i; end
  endfunction

  function automatic int rnd_val();
    case ($urandom_range(0, 4))
      0:       return -32768;
      1:       return 32767;
      2:       return int'($urandom_range(0, 4)) - 2;
      default: return int'(fc_data_t'($urandom_range(0, 65535)));
    endcase
  endfunction

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic drive(input int v, output int waits);
    bit ok = 0;
    waits = 0;
    bus.input_valid = 1'b1;
    bus.input_data  = 16'(v);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.input_ready) begin
        @(posedge clk);
        #1;
        ok = 1;
        break;
      end
      waits++;
    end
    bus.input_valid = 1'b0;
    if (!ok) chk("drive_timeout", 0, 1);
  endtask

  task automatic drive1(input int v);
    bit ok = 0;
    bus1.input_valid = 1'b1;
    bus1.input_data  = 16'(v);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus1.input_ready) begin
        @(posedge clk);
        #1;
        ok = 1;
        break;
      end
    end
    bus1.input_valid = 1'b0;
    if (!ok) chk("drive1_timeout", 0, 1);
  endtask

  task automatic send_frame(input int a, input int b, input int c, input int d);
    int w;
    drive(a, w);
    drive(b, w);
    drive(c, w);
    drive(d, w);
  endtask

  // Scoreboard for the N=4 instance
  initial begin
    hold = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        cur.delete();
        exp_idx.delete();
        exp_val.delete();
        hold = 0;
      end else begin
        if (hold && bus.output_valid) begin
          chk("hold_idx", longint'(bus.output_index), hold_idx);
          chk("hold_val", longint'(bus.output_value), hold_val);
        end
        if (bus.output_valid && bus.output_ready) begin
          if (exp_idx.size() == 0) chk("spurious_out", 1, 0);
          else begin
            chk("out_idx", longint'(bus.output_index), exp_idx.pop_front());
            chk("out_val", longint'(bus.output_value), exp_val.pop_front());
          end
        end
        hold     = bus.output_valid && !bus.output_ready;
        hold_idx = int'(bus.output_index);
        hold_val = int'(bus.output_value);
        if (bus.input_valid && bus.input_ready) begin
          int ri, rv;
          cur.push_back(int'(bus.input_data));
          if (cur.size() == 4) begin
            ref_argmax(cur, ri, rv);
            exp_idx.push_back(ri);
            exp_val.push_back(rv);
            cur.delete();
          end
        end
      end
    end
  end

  // Scoreboard for the N=1 instance: every sample is its own result
  initial forever begin
    @(negedge clk);
    if (!reset) exp1.delete();
    else begin
      if (n1_phase) chk("n1_ready", longint'(bus1.input_ready), longint'(!bus1.output_valid));
      if (bus1.output_valid && bus1.output_ready) begin
        n1_outs++;
        if (exp1.size() == 0) chk("n1_spurious", 1, 0);
        else begin
          chk("n1_idx", longint'(bus1.output_index), 0);
          chk("n1_val", longint'(bus1.output_value), exp1.pop_front());
        end
      end
      if (bus1.input_valid && bus1.input_ready) exp1.push_back(int'(bus1.input_data));
    end
  end

  initial forever begin
    @(posedge clk);
    if (rnd_rdy) begin
      #1;
      bus.output_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int w;
    reset = 0;
    bus.input_valid   = 0;
    bus.input_data    = '0;
    bus.output_ready  = 1;
    bus1.input_valid  = 0;
    bus1.input_data   = '0;
    bus1.output_ready = 1;
    #1;
    chk("rst_valid", longint'(bus.output_valid), 0);
    chk("rst_idx",   longint'(bus.output_index), 0);
    chk("rst_val",   longint'(bus.output_value), 0);
    chk("rst_ready", longint'(bus.input_ready),  0);
    #20 reset = 1;

    // Basic frame and one-cycle result pulse
    send_frame(5, -3, 12, 7);
    chk("t1_valid", longint'(bus.output_valid), 1);
    chk("t1_idx",   longint'(bus.output_index), 2);
    chk("t1_val",   longint'(bus.output_value), 12);
    @(posedge clk); #1;
    chk("t1_pulse", longint'(bus.output_valid), 0);

    send_frame(9, 9, 1, 9);
    chk("tie_idx", longint'(bus.output_index), 0);
    chk("tie_val", longint'(bus.output_value), 9);
    send_frame(-32768, -5, -100, -7);
    chk("neg_idx", longint'(bus.output_index), 1);
    chk("neg_val", longint'(bus.output_value), -5);

    // Backpressure: A parks, B fills up to its last sample
    @(posedge clk); #1;
    bus.output_ready = 0;
    send_frame(1, 2, 3, 4);
    drive(8, w);
    drive(0, w);
    drive(0, w);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_stall", longint'(bus.input_ready), 0);
      chk("bp_a_idx", longint'(bus.output_index), 3);
      chk("bp_a_val", longint'(bus.output_value), 4);
    end
    @(posedge clk); #1;
    bus.output_ready = 1;
    drive(0, w);
    chk("bp_wait",  w, 1);
    chk("bp_b_idx", longint'(bus.output_index), 0);
    chk("bp_b_val", longint'(bus.output_value), 8);

    // Asynchronous reset mid-frame
    drive(50, w);
    drive(60, w);
    #2 reset = 0;
    #1;
    chk("mid_rst_valid", longint'(bus.output_valid), 0);
    chk("mid_rst_idx",   longint'(bus.output_index), 0);
    chk("mid_rst_val",   longint'(bus.output_value), 0);
    chk("mid_rst_ready", longint'(bus.input_ready),  0);
    #14 reset = 1;
    send_frame(-1, -2, -3, -4);
    chk("post_rst_idx", longint'(bus.output_index), 0);
    chk("post_rst_val", longint'(bus.output_value), -1);

    // Randomized frames with random downstream backpressure
    rnd_rdy = 1;
    for (int f = 0; f < 40; f++)
      send_frame(rnd_val(), rnd_val(), rnd_val(), rnd_val());
    rnd_rdy = 0;
    @(posedge clk); #1;
    bus.output_ready = 1;

    // N=1 build
    n1_phase = 1;
    drive1(7);
    drive1(-2);
    drive1(3);
    repeat (4) @(negedge clk);
    n1_phase = 0;

    repeat (10) @(negedge clk);
    chk("sb_empty", exp_idx.size(), 0);
    chk("n1_count", n1_outs, 3);
    chk("n1_empty", exp1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
